// File: rtl/uart_tx_cfg.sv
// Buffered, runtime-configurable UART transmitter: FIFO, baud divisor, parity, 1/2 stop bits.
// Optional line-break generation is enabled by defining UART_TX_BREAK_EN.
module uart_tx_cfg #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_W      = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DIV_W-1:0]              baud_div,
  input  logic [1:0]                    parity_mode,
  input  logic                          two_stop,
  input  logic [DATA_BITS-1:0]          tx_data,
  input  logic                          tx_valid,
`ifdef UART_TX_BREAK_EN
  input  logic                          break_req,
`endif
  output logic                          tx_ready,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
`ifdef UART_TX_BREAK_EN
    , S_BREAK,
    S_GAP
`endif
  } state_t;

  state_t                 state, state_nx;
  logic [DATA_BITS-1:0]   mem [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr, rd_ptr;
  logic [LVL_W-1:0]       level;
  logic [DIV_W-1:0]       div_q, baud_cnt;
  logic                   par_en_q, par_bit_q, two_q, stop_second;
  logic [DATA_BITS-1:0]   shreg;
  logic [3:0]             bit_idx;
  logic                   tx_q, busy_q, tx_nx;
  logic                   push, pop, bit_end, fifo_empty, last_stop;

  assign tx_ready   = (level != LVL_W'(FIFO_DEPTH));
  assign fifo_empty = (level == '0);
  assign push       = tx_valid && tx_ready;
  assign bit_end    = (baud_cnt == div_q);
  assign last_stop  = stop_second || !two_q;
  assign tx         = tx_q;
  assign busy       = busy_q;
  assign fifo_level = level;

  // NOTE: every output of this block gets a default first so no latch can be inferred.
  always_comb begin
    state_nx = state;
    pop      = 1'b0;
    tx_nx    = 1'b1;
    case (state)
      S_IDLE: begin
`ifdef UART_TX_BREAK_EN
        if (break_req) state_nx = S_BREAK;
        else
`endif
        if (!fifo_empty) begin
          pop      = 1'b1;
          state_nx = S_START;
        end
      end
      S_START: begin
        tx_nx = 1'b0;
        if (bit_end) state_nx = S_DATA;
      end
      S_DATA: begin
        tx_nx = shreg[0];
        if (bit_end && bit_idx == 4'(DATA_BITS - 1))
          state_nx = par_en_q ? S_PARITY : S_STOP;
      end
      S_PARITY: begin
        tx_nx = par_bit_q;
        if (bit_end) state_nx = S_STOP;
      end
      S_STOP: begin
        if (bit_end && last_stop) begin
          // Chain straight into the next frame when a word is waiting.
          if (!fifo_empty) begin
            pop      = 1'b1;
            state_nx = S_START;
          end else begin
            state_nx = S_IDLE;
          end
        end
      end
`ifdef UART_TX_BREAK_EN
      S_BREAK: begin
        tx_nx = 1'b0;
        if (!break_req) state_nx = S_GAP;
      end
      S_GAP: begin
        if (bit_end) state_nx = S_IDLE;
      end
`endif
      default: state_nx = S_IDLE;
    endcase
  end

  // NOTE: FIFO storage has no reset; pointers and level define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= tx_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level       <= '0;
      div_q       <= '0;
      baud_cnt    <= '0;
      par_en_q    <= 1'b0;
      par_bit_q   <= 1'b0;
      two_q       <= 1'b0;
      stop_second <= 1'b0;
      shreg       <= '0;
      bit_idx     <= '0;
      tx_q        <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state  <= state_nx;
      tx_q   <= tx_nx;
      busy_q <= (state != S_IDLE) || !fifo_empty;

      if (push) wr_ptr <= wr_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase

      if (pop) begin
        // Line configuration is frozen for the whole frame at pop time.
        rd_ptr      <= rd_ptr + 1'b1;
        shreg       <= mem[rd_ptr];
        div_q       <= baud_div;
        par_en_q    <= ^parity_mode;
        par_bit_q   <= (^mem[rd_ptr]) ^ parity_mode[1];
        two_q       <= two_stop;
        baud_cnt    <= '0;
        bit_idx     <= '0;
        stop_second <= 1'b0;
      end else begin
        if (state != S_IDLE) baud_cnt <= bit_end ? '0 : baud_cnt + 1'b1;
        if (state == S_DATA && bit_end) begin
          shreg   <= shreg >> 1;
          bit_idx <= bit_idx + 1'b1;
        end
        if (state == S_STOP && bit_end) stop_second <= 1'b1;
`ifdef UART_TX_BREAK_EN
        // Gap after a break is timed with the divisor present at release.
        if (state == S_BREAK) begin
          baud_cnt <= '0;
          div_q    <= baud_div;
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Self-checking bench for uart_tx_cfg: line waveforms compared against a frame-level model.
module tb_uart_tx_cfg;

  localparam int DB = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] baud_div;
  logic [1:0]  parity_mode;
  logic        two_stop;
  logic [DB-1:0] tx_data;
  logic        tx_valid;
`ifdef UART_TX_BREAK_EN
  logic        break_req;
`endif
  logic        tx_ready, tx, busy;
  logic [2:0]  fifo_level;

  int checks   = 0;
  int failures = 0;

  logic exp_q[$];
  logic tx_s[$];
  logic busy_s[$];

  uart_tx_cfg #(.DATA_BITS(DB), .FIFO_DEPTH(4), .DIV_W(16)) dut (
    .clk(clk), .rst(rst), .baud_div(baud_div), .parity_mode(parity_mode),
    .two_stop(two_stop), .tx_data(tx_data), .tx_valid(tx_valid),
`ifdef UART_TX_BREAK_EN
    .break_req(break_req),
`endif
    .tx_ready(tx_ready), .tx(tx), .busy(busy), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected line: start, data LSB first, optional parity, stop bit(s); each bit div+1 cycles.
  task automatic add_frame(input logic [DB-1:0] d, input int div, input logic [1:0] pm,
                           input logic two);
    logic b[$];
    b.push_back(1'b0);
    for (int i = 0; i < DB; i++) b.push_back(d[i]);
    if (pm == 2'b01) b.push_back(^d);
    if (pm == 2'b10) b.push_back(~(^d));
    b.push_back(1'b1);
    if (two) b.push_back(1'b1);
    foreach (b[i]) repeat (div + 1) exp_q.push_back(b[i]);
  endtask

  task automatic add_idle(input int n);
    repeat (n) exp_q.push_back(1'b1);
  endtask

  task automatic capture(input string tag);
    int bad = 0;
    tx_s.delete();
    busy_s.delete();
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      tx_s.push_back(tx);
      busy_s.push_back(busy);
      if (tx !== exp_q[i]) bad++;
    end
    check(tag, 32'(bad), 32'd0);
  endtask

  // Push one word into an idle block; returns just after the accepting edge.
  task automatic push_one(input logic [DB-1:0] d);
    @(negedge clk);
    check("push_ready", 32'(tx_ready), 32'd1);
    tx_data  = d;
    tx_valid = 1'b1;
    @(posedge clk);
    #1 tx_valid = 1'b0;
  endtask

  initial begin
    logic [DB-1:0] w1, w2, w3, d;
    int acc, zeros, run, div;
    logic rdy;
    logic [1:0] pm;
    logic two;

    rst = 1'b1; baud_div = 16'd3; parity_mode = 2'b00; two_stop = 1'b0;
    tx_data = '0; tx_valid = 1'b0;
`ifdef UART_TX_BREAK_EN
    break_req = 1'b0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_ready", 32'(tx_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_level", 32'(fifo_level), 32'd0);
    rst = 1'b0;

    // 8N1 0xA5 at baud_div=3
    exp_q.delete(); add_idle(2); add_frame(8'hA5, 3, 2'b00, 1'b0); add_idle(2);
    push_one(8'hA5);
    capture("frame_8n1");
    check("latency_high", 32'(tx_s[1]), 32'd1);
    check("latency_fall", 32'(tx_s[2]), 32'd0);
    check("busy_last_stop", 32'(busy_s[41]), 32'd1);
    check("busy_after", 32'(busy_s[42]), 32'd0);

    // Even / odd parity, then even parity with two stop bits
    parity_mode = 2'b01;
    exp_q.delete(); add_idle(2); add_frame(8'hA5, 3, 2'b01, 1'b0); add_idle(2);
    push_one(8'hA5);
    capture("frame_even");
    check("parity_even_bit", 32'(tx_s[38]), 32'd0);
    parity_mode = 2'b10;
    exp_q.delete(); add_idle(2); add_frame(8'hA5, 3, 2'b10, 1'b0); add_idle(2);
    push_one(8'hA5);
    capture("frame_odd");
    check("parity_odd_bit", 32'(tx_s[38]), 32'd1);
    parity_mode = 2'b01; two_stop = 1'b1;
    exp_q.delete(); add_idle(2); add_frame(8'hA5, 3, 2'b01, 1'b1); add_idle(2);
    push_one(8'hA5);
    capture("frame_even_2stop");
    check("2stop_last_high", 32'(tx_s[49]), 32'd1);
    check("2stop_busy_end", 32'(busy_s[50]), 32'd0);

    // FIFO fill and back-to-back frames at baud_div=9
    baud_div = 16'd9; parity_mode = 2'b00; two_stop = 1'b0;
    exp_q.delete(); add_idle(2);
    for (int k = 1; k <= 5; k++) add_frame(DB'(k), 9, 2'b00, 1'b0);
    add_idle(2);
    @(negedge clk);
    tx_data = 8'h01; tx_valid = 1'b1;
    @(posedge clk);
    #1 acc = 1; tx_data = 8'h02;
    fork
      capture("fifo_b2b");
      begin
        for (int c = 0; c < 30; c++) begin
          @(negedge clk);
          rdy = tx_ready;
          @(posedge clk);
          #1;
          if (rdy) begin
            acc++;
            tx_data = DB'(acc + 1);
          end
        end
        tx_valid = 1'b0;
        check("b2b_accepted", 32'(acc), 32'd5);
        check("full_ready", 32'(tx_ready), 32'd0);
        check("full_level", 32'(fifo_level), 32'd4);
      end
    join
    check("b2b_drained_level", 32'(fifo_level), 32'd0);
    check("b2b_drained_busy", 32'(busy), 32'd0);

    // Config change mid-frame: frame 1 keeps baud_div=3, frame 2 uses 1
    baud_div = 16'd3;
    w1 = DB'($urandom); w2 = DB'($urandom);
    exp_q.delete(); add_idle(1); add_frame(w1, 3, 2'b00, 1'b0); add_frame(w2, 1, 2'b00, 1'b0);
    add_idle(2);
    @(negedge clk);
    tx_data = w1; tx_valid = 1'b1;
    @(posedge clk);
    #1 tx_data = w2;
    @(posedge clk);
    #1 tx_valid = 1'b0; baud_div = 16'd1;
    capture("cfg_change");

    // Randomized frames, including baud_div=0
    for (int r = 0; r < 6; r++) begin
      d   = DB'($urandom);
      div = (r == 0) ? 0 : int'($urandom_range(0, 4));
      pm  = 2'($urandom_range(0, 3));
      two = 1'($urandom_range(0, 1));
      baud_div = 16'(div); parity_mode = pm; two_stop = two;
      exp_q.delete(); add_idle(2); add_frame(d, div, pm, two); add_idle(2);
      push_one(d);
      capture($sformatf("rand_%0d_d%0h_v%0d_p%0d_s%0d", r, d, div, pm, two));
    end

    // Reset mid-frame with two words queued
    baud_div = 16'd3; parity_mode = 2'b00; two_stop = 1'b0;
    w1 = DB'($urandom); w2 = DB'($urandom); w3 = DB'($urandom);
    @(negedge clk);
    tx_data = w1; tx_valid = 1'b1;
    @(posedge clk); #1 tx_data = w2;
    @(posedge clk); #1 tx_data = w3;
    @(posedge clk); #1 tx_valid = 1'b0;
    repeat (17) @(negedge clk);
    check("pre_rst_bit3", 32'(tx), 32'(w1[3]));
    check("pre_rst_level", 32'(fifo_level), 32'd2);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_tx", 32'(tx), 32'd1);
    check("midrst_level", 32'(fifo_level), 32'd0);
    check("midrst_ready", 32'(tx_ready), 32'd1);
    check("midrst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    zeros = 0;
    repeat (120) begin
      @(negedge clk);
      if (tx !== 1'b1) zeros++;
    end
    check("post_rst_silent", 32'(zeros), 32'd0);
    check("post_rst_level", 32'(fifo_level), 32'd0);

`ifdef UART_TX_BREAK_EN
    // Break for 20 cycles while idle with a word queued
    baud_div = 16'd3;
    w1 = DB'($urandom);
    @(negedge clk);
    break_req = 1'b1; tx_data = w1; tx_valid = 1'b1;
    @(posedge clk);
    #1 tx_valid = 1'b0;
    tx_s.delete();
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      tx_s.push_back(tx);
      if (i == 19) break_req = 1'b0;
    end
    zeros = 0;
    for (int i = 1; i <= 20; i++) if (tx_s[i] === 1'b0) zeros++;
    check("break_low", 32'(zeros), 32'd20);
    run = 0;
    for (int i = 21; i < 60 && tx_s[i] === 1'b1; i++) run++;
    check("break_gap_min", 32'(run >= 4), 32'd1);
    check("break_then_start", 32'(tx_s[21 + run]), 32'd0);
    check("break_first_data", 32'(tx_s[21 + run + 4]), 32'(w1[0]));
    repeat (40) @(negedge clk);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
